l2ram_arbiter: RTL and testbench
================================

L2RAM_ARBITER -- requirements
Module: l2ram_arbiter

Interface
REQ-001 Parameter DW, default 48, RAM word width in bits.
REQ-002 Parameter AW, default 4, RAM address width in bits (16 entries).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, on ports named clock and reset.
REQ-004 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-007 reqN_write  input  1  1 = write, 0 = read.
REQ-008 reqN_addr  input  AW  target address.
REQ-009 reqN_wdata  input  DW  write data; ignored for reads.
REQ-010 reqN_ready  output  1  operation accepted this cycle (combinational grant).
REQ-011 rspN_valid  output  1  read data for requester N valid this cycle.
REQ-012 rspN_rdata  output  DW  read data.
REQ-013 ram_data  output  DW  to RAM data.
REQ-014 ram_wraddress  output  AW  to RAM write address.
REQ-015 ram_wren  output  1  to RAM write enable.
REQ-016 ram_rdaddress  output  AW  to RAM read address.
REQ-017 ram_q  input  DW  from RAM; registered read data, valid one cycle after the address is presented.

Function
REQ-018 Transfer SHALL occur when reqN_valid && reqN_ready; the requester holds valid and all fields stable until transfer.
REQ-019 reqN_ready SHALL never assert while reqN_valid is 0.
REQ-020 Single requester valid: granted the same cycle, no stall.
REQ-021 Both valid, one read and one write: both granted the same cycle (read port and write port in parallel).
REQ-022 Both valid, same operation type: only requester rr_ptr is granted; the other stalls.
REQ-023 rr_ptr (1 bit) SHALL toggle only after a contended grant (REQ-022) and hold otherwise.
REQ-024 Write granted: ram_wren=1, ram_wraddress/ram_data from the winner; no write granted: ram_wren=0, ram_wraddress=0, ram_data=0.
REQ-025 Read granted: ram_rdaddress from the winner; otherwise 0.
REQ-026 rspN_valid SHALL assert for exactly one cycle, the cycle after a read grant to N; latency is fixed at 1.
REQ-027 rspN_rdata SHALL be ram_q when rspN_valid=1 and 0 when rspN_valid=0.
REQ-028 Same-cycle read and write grant to the same address: the response SHALL return the new write data (forwarded from a registered copy), not the old RAM contents.
REQ-029 Same-cycle read and write to different addresses: no forwarding; the response returns ram_q.
REQ-030 Back-to-back reads from one requester SHALL sustain one response per cycle.
REQ-031 The block SHALL hold no request queue; total registered state is rr_ptr, the response-valid/owner flags, the forward flag and the forward data.

Reset
REQ-032 Reset SHALL asynchronously clear rr_ptr=0, rsp0_valid=rsp1_valid=0, the forward flag=0 and the forward data=0.
REQ-033 Reset asserted mid-operation SHALL drop any pending response; no rspN_valid pulse after reset deasserts.
REQ-034 While reset is high, reqN_ready=0 and ram_wren=0.

Verification
REQ-035 Req0 writes 0x123456789ABC to addr 3; next cycle req0 reads addr 3 -> ready0=1 in both cycles; rsp0_valid=1 two cycles after the write with rsp0_rdata=0x123456789ABC.
REQ-036 Req0 and req1 both read (addr 1, addr 2) from reset -> cycle0 grants req0 only; cycle1 grants req1; rr_ptr=0 after the second grant; one response per cycle, each routed to its owner.
REQ-037 Req0 reads addr 5 while req1 writes 0xAAAA_BBBB_CCCC to addr 5 in the same cycle -> both ready; next cycle rsp0_valid=1, rsp0_rdata=0xAAAABBBBCCCC (forwarded).
REQ-038 Req0 reads addr 6 while req1 writes addr 7 -> both granted; rsp0_rdata = prior contents of addr 6; addr 7 updated.
REQ-039 Reset pulsed in the cycle after a read grant -> rspN_valid stays 0; rr_ptr=0; the first post-reset contention grants req0.
REQ-040 Random valid/write/address traffic against a 16-entry reference model -> every read response matches the model; no requester waits more than 1 cycle under contention.

Source files
------------

// File: rtl/l2ram_arbiter.sv
// Two-requester arbiter in front of a simple dual-port RAM (one read port, one write port).
// Grants are combinational; read data returns one cycle later with same-address write forwarding.
module l2ram_arbiter #(
    parameter int DW = 48,
    parameter int AW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic          req0_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic          req1_write,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_wraddress,
    output logic          ram_wren,
    output logic [AW-1:0] ram_rdaddress,
    input  logic [DW-1:0] ram_q
);

    logic          rr_q, rr_d;
    logic          rsp0_q, rsp0_d;
    logic          rsp1_q, rsp1_d;
    logic          fwd_q, fwd_d;
    logic [DW-1:0] fwd_data_q, fwd_data_d;

    logic gnt0, gnt1, contend;
    logic rd_g0, rd_g1, wr_g0, wr_g1;
    logic [DW-1:0] rsp_data;

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        contend = 1'b0;
        if (!reset) begin
            // Only a same-type collision competes for a port; mixed read/write run in parallel.
            if (req0_valid && req1_valid && (req0_write == req1_write)) begin
                contend = 1'b1;
                gnt0    = ~rr_q;
                gnt1    = rr_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end

        rd_g0 = gnt0 & ~req0_write;
        rd_g1 = gnt1 & ~req1_write;
        wr_g0 = gnt0 & req0_write;
        wr_g1 = gnt1 & req1_write;

        req0_ready = gnt0;
        req1_ready = gnt1;

        ram_wren      = wr_g0 | wr_g1;
        ram_wraddress = '0;
        ram_data      = '0;
        if (wr_g1) begin
            ram_wraddress = req1_addr;
            ram_data      = req1_wdata;
        end else if (wr_g0) begin
            ram_wraddress = req0_addr;
            ram_data      = req0_wdata;
        end

        ram_rdaddress = '0;
        if (rd_g1)      ram_rdaddress = req1_addr;
        else if (rd_g0) ram_rdaddress = req0_addr;

        rr_d   = contend ? ~rr_q : rr_q;
        rsp0_d = rd_g0;
        rsp1_d = rd_g1;
        // RAM returns old contents on a same-cycle read/write collision, so keep the new word.
        fwd_d      = (rd_g0 | rd_g1) & ram_wren & (ram_rdaddress == ram_wraddress);
        fwd_data_d = fwd_d ? ram_data : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q       <= 1'b0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            rr_q       <= rr_d;
            rsp0_q     <= rsp0_d;
            rsp1_q     <= rsp1_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    always_comb begin
        rsp_data   = fwd_q ? fwd_data_q : ram_q;
        rsp0_valid = rsp0_q;
        rsp1_valid = rsp1_q;
        rsp0_rdata = rsp0_q ? rsp_data : '0;
        rsp1_rdata = rsp1_q ? rsp_data : '0;
    end

endmodule

// File: tb/tb_l2ram_arbiter.sv
// Directed and randomized bench for l2ram_arbiter with a behavioural registered-output RAM.
module tb_l2ram_arbiter;
    localparam int DW = 48;
    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0_valid, req0_write, req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_write, req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic [DW-1:0] ram_data, ram_q;
    logic [AW-1:0] ram_wraddress, ram_rdaddress;
    logic          ram_wren;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mem     [16];
    logic [DW-1:0] ref_mem [16];

    l2ram_arbiter #(.DW(DW), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_data(ram_data), .ram_wraddress(ram_wraddress), .ram_wren(ram_wren),
        .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    // Registered-output RAM: a same-edge read of a written address returns the old word.
    always @(posedge clock) begin
        if (ram_wren) mem[ram_wraddress] <= ram_data;
        ram_q <= mem[ram_rdaddress];
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int n, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (n == 0) begin
            req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    logic          x0, x1, nv0, nv1;
    logic [DW-1:0] nd0, nd1;
    logic [63:0]   r64;
    int            w0cnt, w1cnt;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b1;
        idle();
        drive(0, 1'b1, 1'b0, 4'd3, '0);
        #2;
        chk1("rst_ready0", req0_ready, 1'b0);
        chk1("rst_wren", ram_wren, 1'b0);
        chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
        chkd("rst_rsp0_rdata", rsp0_rdata, '0);
        tick(); tick();
        idle();
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Write then read back from one requester
        drive(0, 1'b1, 1'b1, 4'd3, 48'h123456789ABC);
        mid();
        chk1("t1_wr_ready0", req0_ready, 1'b1);
        chk1("t1_wr_ready1", req1_ready, 1'b0);
        chk1("t1_wren", ram_wren, 1'b1);
        chka("t1_wraddr", ram_wraddress, 4'd3);
        chkd("t1_wdata", ram_data, 48'h123456789ABC);
        tick();
        drive(0, 1'b1, 1'b0, 4'd3, '0);
        mid();
        chk1("t1_rd_ready0", req0_ready, 1'b1);
        chk1("t1_rd_wren", ram_wren, 1'b0);
        chka("t1_rd_wraddr_idle", ram_wraddress, 4'd0);
        chkd("t1_rd_wdata_idle", ram_data, '0);
        chka("t1_rdaddr", ram_rdaddress, 4'd3);
        chk1("t1_no_rsp_for_write", rsp0_valid, 1'b0);
        tick();
        idle();
        chk1("t1_rsp0_valid", rsp0_valid, 1'b1);
        chkd("t1_rsp0_rdata", rsp0_rdata, 48'h123456789ABC);
        chk1("t1_rsp1_quiet", rsp1_valid, 1'b0);
        tick();
        chk1("t1_rsp0_single", rsp0_valid, 1'b0);
        chkd("t1_rsp0_zero", rsp0_rdata, '0);

        // Contended reads alternate and route responses to their owners
        drive(0, 1'b1, 1'b1, 4'd1, 48'h000000000111); tick();
        drive(0, 1'b1, 1'b1, 4'd2, 48'h000000000222); tick();
        drive(0, 1'b1, 1'b0, 4'd1, '0);
        drive(1, 1'b1, 1'b0, 4'd2, '0);
        mid();
        chk1("t2_c0_ready0", req0_ready, 1'b1);
        chk1("t2_c0_ready1", req1_ready, 1'b0);
        chka("t2_c0_rdaddr", ram_rdaddress, 4'd1);
        tick();
        chk1("t2_c0_rsp0_valid", rsp0_valid, 1'b1);
        chkd("t2_c0_rsp0_rdata", rsp0_rdata, 48'h000000000111);
        mid();
        chk1("t2_c1_ready0", req0_ready, 1'b0);
        chk1("t2_c1_ready1", req1_ready, 1'b1);
        chka("t2_c1_rdaddr", ram_rdaddress, 4'd2);
        tick();
        chk1("t2_c1_rsp1_valid", rsp1_valid, 1'b1);
        chkd("t2_c1_rsp1_rdata", rsp1_rdata, 48'h000000000222);
        chk1("t2_c1_rsp0_quiet", rsp0_valid, 1'b0);
        mid();
        chk1("t2_c2_ready0", req0_ready, 1'b1);
        chk1("t2_c2_ready1", req1_ready, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0, '0, '0);
        chkd("t2_c2_rsp0_rdata", rsp0_rdata, 48'h000000000111);
        mid();
        chk1("t2_c3_ready1", req1_ready, 1'b1);
        tick();
        idle();
        chkd("t2_c3_rsp1_rdata", rsp1_rdata, 48'h000000000222);

        // Contended writes: pointer left at 1, so req1 wins first
        drive(0, 1'b1, 1'b1, 4'd8, 48'h000000000808);
        drive(1, 1'b1, 1'b1, 4'd9, 48'h000000000909);
        mid();
        chk1("t3_ready0", req0_ready, 1'b0);
        chk1("t3_ready1", req1_ready, 1'b1);
        chka("t3_wraddr", ram_wraddress, 4'd9);
        chkd("t3_wdata", ram_data, 48'h000000000909);
        tick();
        drive(1, 1'b0, 1'b0, '0, '0);
        mid();
        chk1("t3b_ready0", req0_ready, 1'b1);
        chka("t3b_wraddr", ram_wraddress, 4'd8);
        tick();
        idle();

        // Same-address read and write: forwarded data
        drive(0, 1'b1, 1'b0, 4'd5, '0);
        drive(1, 1'b1, 1'b1, 4'd5, 48'hAAAABBBBCCCC);
        mid();
        chk1("t4_ready0", req0_ready, 1'b1);
        chk1("t4_ready1", req1_ready, 1'b1);
        chk1("t4_wren", ram_wren, 1'b1);
        chka("t4_rdaddr", ram_rdaddress, 4'd5);
        tick();
        idle();
        chk1("t4_rsp0_valid", rsp0_valid, 1'b1);
        chkd("t4_rsp0_fwd", rsp0_rdata, 48'hAAAABBBBCCCC);
        chk1("t4_rsp1_quiet", rsp1_valid, 1'b0);
        tick();
        chk1("t4_rsp0_single", rsp0_valid, 1'b0);

        // Different-address read and write: no forwarding
        drive(0, 1'b1, 1'b1, 4'd6, 48'h000000000666); tick();
        drive(0, 1'b1, 1'b0, 4'd6, '0);
        drive(1, 1'b1, 1'b1, 4'd7, 48'h000000000777);
        mid();
        chk1("t5_ready0", req0_ready, 1'b1);
        chk1("t5_ready1", req1_ready, 1'b1);
        tick();
        idle();
        chkd("t5_rsp0_old", rsp0_rdata, 48'h000000000666);
        drive(1, 1'b1, 1'b0, 4'd7, '0);
        mid();
        chk1("t5b_ready1", req1_ready, 1'b1);
        chka("t5b_rdaddr", ram_rdaddress, 4'd7);
        tick();
        idle();
        chk1("t5b_rsp1_valid", rsp1_valid, 1'b1);
        chkd("t5b_rsp1_rdata", rsp1_rdata, 48'h000000000777);

        // Reset right after a read grant drops the response and clears the pointer
        drive(0, 1'b1, 1'b0, 4'd1, '0);
        drive(1, 1'b1, 1'b0, 4'd2, '0);
        mid();
        chk1("t6_ready0", req0_ready, 1'b1);
        tick();
        drive(1, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        #1;
        chk1("t6_rsp0_dropped", rsp0_valid, 1'b0);
        chk1("t6_ready_in_reset", req0_ready, 1'b0);
        chk1("t6_wren_in_reset", ram_wren, 1'b0);
        tick();
        idle();
        tick();
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk1("t6_post_rsp0", rsp0_valid, 1'b0);
        chk1("t6_post_rsp1", rsp1_valid, 1'b0);
        drive(0, 1'b1, 1'b0, 4'd1, '0);
        drive(1, 1'b1, 1'b0, 4'd2, '0);
        mid();
        chk1("t6_first_ready0", req0_ready, 1'b1);
        chk1("t6_first_ready1", req1_ready, 1'b0);
        tick();
        idle();
        tick();

        // Randomized traffic against a reference memory
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 48'h5A5A00000000 + 48'(i) * 48'h000100010001;
            drive(0, 1'b1, 1'b1, 4'(i), ref_mem[i]);
            tick();
        end
        idle();
        tick();
        x0 = 1'b0; x1 = 1'b0; w0cnt = 0; w1cnt = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!req0_valid || x0) begin
                r64 = {$urandom, $urandom};
                drive(0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), r64[47:0]);
            end
            if (!req1_valid || x1) begin
                r64 = {$urandom, $urandom};
                drive(1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), r64[47:0]);
            end
            mid();
            if (!req0_valid) chk1("rnd_ready0_idle", req0_ready, 1'b0);
            if (!req1_valid) chk1("rnd_ready1_idle", req1_ready, 1'b0);
            x0 = req0_valid & req0_ready;
            x1 = req1_valid & req1_ready;
            if (x0) w0cnt = 0; else if (req0_valid) w0cnt++;
            if (x1) w1cnt = 0; else if (req1_valid) w1cnt++;
            chk1("rnd_wait0", (w0cnt <= 1), 1'b1);
            chk1("rnd_wait1", (w1cnt <= 1), 1'b1);
            if (x0 && req0_write) ref_mem[req0_addr] = req0_wdata;
            if (x1 && req1_write) ref_mem[req1_addr] = req1_wdata;
            nv0 = x0 & ~req0_write;
            nv1 = x1 & ~req1_write;
            nd0 = nv0 ? ref_mem[req0_addr] : '0;
            nd1 = nv1 ? ref_mem[req1_addr] : '0;
            tick();
            chk1("rnd_rsp0_valid", rsp0_valid, nv0);
            chk1("rnd_rsp1_valid", rsp1_valid, nv1);
            chkd("rnd_rsp0_rdata", rsp0_rdata, nd0);
            chkd("rnd_rsp1_rdata", rsp1_rdata, nd1);
        end
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
